// File: rtl/stack_arbiter.sv
// Round-robin arbiter giving two requesters (A, B) shared push/pop access to one Stack.
// Full/empty are pre-checked so rejected requests never strobe the Stack.
module stack_arbiter #(
    parameter int WORD_LEN = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                a_req,
    input  logic                a_op,
    input  logic [WORD_LEN-1:0] a_wdata,
    output logic                a_ack,
    output logic                a_err,
    output logic [WORD_LEN-1:0] a_rdata,
    input  logic                b_req,
    input  logic                b_op,
    input  logic [WORD_LEN-1:0] b_wdata,
    output logic                b_ack,
    output logic                b_err,
    output logic [WORD_LEN-1:0] b_rdata,
    output logic                busy,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [WORD_LEN-1:0] stk_din,
    input  logic [WORD_LEN-1:0] stk_dout,
    input  logic                stk_full,
    input  logic                stk_empty
);

    // Handshake: a requester raises req with op/wdata and holds it until its ack
    // pulses for one cycle; err and rdata are meaningful only in that ack cycle.
    // req still high in the cycle after ack starts a new transaction.

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;

    state_t state, state_nx;
    logic   rr_ptr, rr_nx;         // 0 = A has priority on a tie, 1 = B
    logic   gnt_id, gnt_id_nx;     // 0 = A, 1 = B
    logic   gnt_op, gnt_op_nx;     // 0 = push, 1 = pop

    logic                a_ack_nx, a_err_nx, b_ack_nx, b_err_nx;
    logic [WORD_LEN-1:0] a_rdata_nx, b_rdata_nx;
    logic                stk_push_nx, stk_pop_nx, busy_nx;
    logic [WORD_LEN-1:0] stk_din_nx;

    logic                pick;
    logic                pick_op;
    logic [WORD_LEN-1:0] pick_wdata;
    logic                reject;

    assign pick       = (a_req && b_req) ? rr_ptr : b_req;
    assign pick_op    = pick ? b_op : a_op;
    assign pick_wdata = pick ? b_wdata : a_wdata;
    assign reject     = pick_op ? stk_empty : stk_full;

    always_comb begin
        state_nx    = state;
        rr_nx       = rr_ptr;
        gnt_id_nx   = gnt_id;
        gnt_op_nx   = gnt_op;
        a_ack_nx    = 1'b0;
        a_err_nx    = 1'b0;
        b_ack_nx    = 1'b0;
        b_err_nx    = 1'b0;
        a_rdata_nx  = a_rdata;
        b_rdata_nx  = b_rdata;
        stk_push_nx = 1'b0;
        stk_pop_nx  = 1'b0;
        stk_din_nx  = '0;

        case (state)
            IDLE: begin
                if (a_req || b_req) begin
                    gnt_id_nx = pick;
                    gnt_op_nx = pick_op;
                    rr_nx     = ~pick;
                    if (reject) begin
                        state_nx = ACK;
                        a_ack_nx = ~pick;
                        a_err_nx = ~pick;
                        b_ack_nx = pick;
                        b_err_nx = pick;
                    end else begin
                        state_nx    = ISSUE;
                        stk_push_nx = ~pick_op;
                        stk_pop_nx  = pick_op;
                        if (!pick_op) stk_din_nx = pick_wdata;
                    end
                end
            end
            ISSUE: begin
                if (gnt_op) begin
                    state_nx = CAPT;
                end else begin
                    state_nx = ACK;
                    a_ack_nx = ~gnt_id;
                    b_ack_nx = gnt_id;
                end
            end
            CAPT: begin
                // Stack updated stk_dout at the edge ending ISSUE
                state_nx = ACK;
                a_ack_nx = ~gnt_id;
                b_ack_nx = gnt_id;
                if (gnt_id) b_rdata_nx = stk_dout;
                else        a_rdata_nx = stk_dout;
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            gnt_id   <= 1'b0;
            gnt_op   <= 1'b0;
            a_ack    <= 1'b0;
            a_err    <= 1'b0;
            b_ack    <= 1'b0;
            b_err    <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
            stk_push <= 1'b0;
            stk_pop  <= 1'b0;
            stk_din  <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            rr_ptr   <= rr_nx;
            gnt_id   <= gnt_id_nx;
            gnt_op   <= gnt_op_nx;
            a_ack    <= a_ack_nx;
            a_err    <= a_err_nx;
            b_ack    <= b_ack_nx;
            b_err    <= b_err_nx;
            a_rdata  <= a_rdata_nx;
            b_rdata  <= b_rdata_nx;
            stk_push <= stk_push_nx;
            stk_pop  <= stk_pop_nx;
            stk_din  <= stk_din_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a depth-8 Stack model sits behind the arbiter and a
// reference LIFO predicts ack latency, err and rdata for every transaction.
module tb_stack_arbiter;

    localparam int W     = 8;
    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         a_req = 1'b0, a_op = 1'b0, b_req = 1'b0, b_op = 1'b0;
    logic [W-1:0] a_wdata = '0, b_wdata = '0;
    logic         a_ack, a_err, b_ack, b_err, busy, stk_push, stk_pop;
    logic [W-1:0] a_rdata, b_rdata, stk_din;
    logic [W-1:0] stk_dout;
    logic         stk_full, stk_empty;

    int total = 0;
    int bad   = 0;
    int push_cnt = 0;
    int pop_cnt  = 0;

    // Expected per transaction: {ack_seen, latency[3:0], err, rdata}
    logic [13:0]  exp_q[$];
    bit           gnt_q[$];
    logic [W-1:0] ref_q[$];
    logic [W-1:0] a_last = '0, b_last = '0;

    always #5 clk = ~clk;

    stack_arbiter #(.WORD_LEN(W)) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .busy(busy), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_dout(stk_dout), .stk_full(stk_full), .stk_empty(stk_empty)
    );

    // Stack attached to the arbiter
    logic [W-1:0] env_mem [DEPTH];
    logic [3:0]   env_sp;
    logic [2:0]   top_idx;
    assign top_idx   = 3'(env_sp - 4'd1);
    assign stk_full  = (env_sp == 4'd8);
    assign stk_empty = (env_sp == 4'd0);

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            env_sp   <= 4'd0;
            stk_dout <= '0;
        end else if (stk_push && !stk_full) begin
            env_mem[env_sp[2:0]] <= stk_din;
            env_sp <= env_sp + 4'd1;
        end else if (stk_pop && !stk_empty) begin
            stk_dout <= env_mem[top_idx];
            env_sp   <= env_sp - 4'd1;
        end
    end

    always @(negedge clk) begin
        if (stk_push) push_cnt++;
        if (stk_pop)  pop_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b0;
        rstn  = 1'b1;
        ref_q.delete();
        a_last = '0;
        b_last = '0;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    task automatic drive_txn(input bit side, input bit op, input logic [W-1:0] wd,
                             output logic [13:0] obs);
        bit           e;
        logic [W-1:0] rd;
        int           lat, n;
        bit           got;
        if (!op) begin
            e = (ref_q.size() == DEPTH);
            if (!e) ref_q.push_back(wd);
            rd  = side ? b_last : a_last;
            lat = e ? 1 : 2;
        end else begin
            e = (ref_q.size() == 0);
            if (e) begin
                rd = side ? b_last : a_last;
            end else begin
                rd = ref_q.pop_back();
                if (side) b_last = rd;
                else      a_last = rd;
            end
            lat = e ? 1 : 3;
        end
        exp_q.push_back({1'b1, 4'(lat), e, rd});

        @(negedge clk);
        if (side) begin b_req = 1'b1; b_op = op; b_wdata = wd; end
        else      begin a_req = 1'b1; a_op = op; a_wdata = wd; end
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = side ? b_ack : a_ack;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        obs = {got, 4'(n), side ? b_err : a_err, side ? b_rdata : a_rdata};
    endtask

    task automatic test_reset();
        logic [30:0] outs;
        logic [13:0] obs, exp;
        @(negedge clk);
        outs = {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, busy, stk_push, stk_pop, stk_din};
        total++;
        if (outs !== 31'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        rstn = 1'b0;

        drive_txn(1'b0, 1'b0, 8'h33, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL reset_pre_push: got %h required %h", obs, exp); end

        // Start a pop and reset it while in CAPT
        @(negedge clk);
        a_req = 1'b1; a_op = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy_capt: got %b required 1", busy); end
        rstn = 1'b1;
        #1;
        outs = {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, busy, stk_push, stk_pop, stk_din};
        total++;
        if (outs !== 31'b0) begin bad++; $display("FAIL reset_mid_pop: got %h required 0", outs); end
        a_req = 1'b0;
        ref_q.delete();
        a_last = '0;
        b_last = '0;
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({a_ack, busy} !== 2'b00) begin
                bad++;
                $display("FAIL reset_no_ack: a_ack=%b busy=%b required 0 0", a_ack, busy);
            end
        end
    endtask

    task automatic test_push_pop_a();
        logic [13:0] obs, exp;
        drive_txn(1'b0, 1'b0, 8'h5A, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL a_push_5a: got %h required %h", obs, exp); end
        drive_txn(1'b0, 1'b1, 8'h00, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL a_pop_5a: got %h required %h", obs, exp); end
    endtask

    task automatic test_arbitration();
        int acks, cyc;
        bit exp_side;
        do_reset();
        for (int i = 0; i < 8; i++) gnt_q.push_back(i % 2 == 1);
        @(negedge clk);
        a_req = 1'b1; a_op = 1'b0; a_wdata = 8'h11;
        b_req = 1'b1; b_op = 1'b0; b_wdata = 8'h22;
        acks = 0;
        cyc  = 0;
        while (acks < 8 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            total++;
            if ((stk_push && stk_pop) || (a_ack && b_ack)) begin
                bad++;
                $display("FAIL arb_overlap: push=%b pop=%b a_ack=%b b_ack=%b required no overlap",
                         stk_push, stk_pop, a_ack, b_ack);
            end
            if (a_ack || b_ack) begin
                exp_side = gnt_q.pop_front();
                total++;
                if ({b_ack, a_err | b_err} !== {exp_side, 1'b0}) begin
                    bad++;
                    $display("FAIL arb_order: ack %0d side=%b err=%b required side=%b err=0",
                             acks, b_ack, a_err | b_err, exp_side);
                end
                acks++;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        total++;
        if (acks !== 8) begin bad++; $display("FAIL arb_count: got %0d acks required 8", acks); end
        gnt_q.delete();
    endtask

    task automatic test_pop_empty();
        logic [13:0] obs, exp;
        int p0;
        do_reset();
        p0 = pop_cnt;
        drive_txn(1'b1, 1'b1, 8'h00, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL b_pop_empty: got %h required %h", obs, exp); end
        total++;
        if (pop_cnt !== p0) begin bad++; $display("FAIL b_pop_empty_strobe: got %0d pops required 0", pop_cnt - p0); end
    endtask

    task automatic test_push_full();
        logic [13:0] obs, exp;
        int p0;
        p0 = push_cnt;
        for (int i = 1; i <= 9; i++) begin
            drive_txn(1'b0, 1'b0, 8'(i), obs);
            exp = exp_q.pop_front();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL full_push_%0d: got %h required %h", i, obs, exp); end
        end
        total++;
        if (push_cnt - p0 !== 8) begin bad++; $display("FAIL full_push_strobes: got %0d required 8", push_cnt - p0); end
        for (int i = 1; i <= 9; i++) begin
            drive_txn(1'b0, 1'b1, 8'h00, obs);
            exp = exp_q.pop_front();
            total++;
            if (obs !== exp) begin bad++; $display("FAIL full_pop_%0d: got %h required %h", i, obs, exp); end
        end
    endtask

    task automatic test_lifo_sides();
        logic [13:0] obs, exp;
        drive_txn(1'b0, 1'b0, 8'hAA, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lifo_a_push: got %h required %h", obs, exp); end
        drive_txn(1'b1, 1'b0, 8'hBB, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lifo_b_push: got %h required %h", obs, exp); end
        drive_txn(1'b0, 1'b1, 8'h00, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lifo_a_pop: got %h required %h", obs, exp); end
        drive_txn(1'b1, 1'b1, 8'h00, obs);
        exp = exp_q.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lifo_b_pop: got %h required %h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_push_pop_a();
        test_arbitration();
        test_pop_empty();
        test_push_full();
        test_lifo_sides();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
